uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1085, clock cycles per serial bit (115200 baud at 125 MHz); legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, range 2..16.
REQ-006 i_clock  input  1  single clock; all state changes on its rising edge.
REQ-007 i_reset  input  1  reset, synchronous and active-high.
REQ-008 i_tx_start  input  1  write request; the rising edge is detected internally.
REQ-009 i_tx_data  input  DATA_BITS  byte captured on a detected i_tx_start rising edge.
REQ-010 o_tx  output  1  serial line, idle high.
REQ-011 o_tx_busy  output  1  high while a frame is being shifted out.
REQ-012 o_tx_done  output  1  one-cycle pulse on the final cycle of each frame's last stop bit.
REQ-013 o_fifo_full / o_fifo_empty  output  1 each  FIFO status flags, registered.
REQ-014 o_overflow  output  1  sticky flag; set when a write is dropped.

Function
REQ-015 Edge detect: a write is requested only in the cycle where i_tx_start=1 and its registered previous value=0; a level held high for any length SHALL produce exactly one write.
REQ-016 Write acceptance: the request is accepted if o_fifo_full=0 at that edge. Fullness is evaluated before any same-cycle pop, so a write on a full FIFO is dropped even if a pop occurs on the same edge.
REQ-017 A dropped write SHALL set o_overflow=1, which holds until reset; FIFO contents are unchanged.
REQ-018 FIFO: circular buffer with wrapping read/write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1. Full when count=FIFO_DEPTH; empty when count=0.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: o_tx=1 and o_tx_busy=0. If the FIFO is non-empty, the block pops the head entry into the shift register, clears the bit counter and baud counter, and enters START.
REQ-021 Latency: a write accepted at edge k into an empty FIFO, with the FSM idle, SHALL drive o_tx=0 from edge k+1.
REQ-022 START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-023 DATA: transmit DATA_BITS bits, LSB first, each lasting exactly CLKS_PER_BIT cycles; then go to PARITY if PARITY!=0, otherwise to STOP.
REQ-024 PARITY: odd mode sends the bit that makes the count of ones (data plus parity) odd; even mode makes it even; the bit lasts CLKS_PER_BIT cycles.
REQ-025 STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles; o_tx_done pulses in the final cycle.
REQ-026 At the end of STOP, if the FIFO is non-empty, the block pops and enters START directly with zero idle cycles between frames; otherwise it returns to IDLE.
REQ-027 Frame length SHALL be exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-028 o_tx_busy=1 in every state except IDLE; o_tx is driven from a register (glitch-free).
REQ-029 Simultaneous push and pop on a non-full FIFO: both take effect and the count is unchanged.

Reset
REQ-030 While i_reset=1 at a rising edge, the block SHALL force the FSM to IDLE and set o_tx=1, o_tx_busy=0, o_tx_done=0, o_fifo_empty=1, o_fifo_full=0, o_overflow=0, pointers/count=0, and the edge-detect register=0.
REQ-031 Reset mid-frame SHALL abort the frame: o_tx=1 from the reset edge, the FIFO is flushed, and no o_tx_done is issued.
REQ-032 i_tx_start held high across reset deassertion SHALL produce one write on the first cycle after reset.

Verification
REQ-033 CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1; write 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles, 44 cycles total, o_tx_done on cycle 44.
REQ-034 Same configuration with PARITY=1, write 0x01 -> parity bit=0; with PARITY=2 -> parity bit=1.
REQ-035 i_tx_start held high for 125 cycles -> exactly one frame is sent, and o_overflow stays 0.
REQ-036 FIFO_DEPTH=4, five writes pulsed during the first frame -> o_fifo_full=1 after the 4th write, o_overflow=1 after the 5th, 5 frames sent back-to-back with no gap, then o_fifo_empty=1.
REQ-037 Assert i_reset at cycle 20 of a frame -> o_tx=1 the next cycle, o_tx_busy=0, FIFO empty, no o_tx_done pulse.
REQ-038 DATA_BITS=5, PARITY=0, STOP_BITS=2, CLKS_PER_BIT=3; write 0x1F -> 8-bit frame of 24 cycles: 0,1,1,1,1,1,1,1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of it.
//
// A rising edge on i_tx_start queues i_tx_data. The transmitter pops queued
// bytes and sends frames of start bit, DATA_BITS data bits (LSB first), an
// optional parity bit and STOP_BITS stop bits, each bit CLKS_PER_BIT cycles.
// Queued frames go out back-to-back with no idle cycles between them.
//
// Ports:
//   i_clock       clock, all state changes on the rising edge
//   i_reset       synchronous active-high reset; aborts any frame, flushes FIFO
//   i_tx_start    write request (rising edge detected internally)
//   i_tx_data     byte queued on a detected i_tx_start rising edge
//   o_tx          serial line, idle high, driven from a register
//   o_tx_busy     high while a frame is being shifted out
//   o_tx_done     one-cycle pulse in the last cycle of each frame
//   o_fifo_full   FIFO full flag (registered)
//   o_fifo_empty  FIFO empty flag (registered)
//   o_overflow    sticky: a write was dropped because the FIFO was full
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 1085,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done,
    output logic                 o_fifo_full,
    output logic                 o_fifo_empty,
    output logic                 o_overflow
);

    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW       = PtrW + 1;
    localparam int unsigned StopCycles = STOP_BITS * CLKS_PER_BIT;
    // One counter times both single bits and the whole stop period.
    localparam int unsigned BaudW      = $clog2(StopCycles);
    localparam int unsigned BitW       = $clog2(DATA_BITS);

    localparam logic [BaudW-1:0] BitLast  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] StopLast = BaudW'(StopCycles - 1);
    localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic [BaudW-1:0]     baud_q, baud_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 start_q;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 full_q, empty_q, ovf_q;

    logic                 write_req, push, pop, launch;
    logic [DATA_BITS-1:0] head;

    assign write_req = i_tx_start & ~start_q;
    // Fullness is the registered flag, so a same-cycle pop cannot rescue a write.
    assign push      = write_req & ~full_q;
    assign pop       = launch;
    assign head      = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        launch  = 1'b0;
        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                baud_d = '0;
                launch = ~empty_q;
            end
            StStart: begin
                if (baud_q == BitLast) begin
                    state_d = StData;
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (baud_q == BitLast) begin
                    baud_d = '0;
                    if (bit_q == DataLast) begin
                        if (PARITY != 0) begin
                            state_d = StParity;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (baud_q == BitLast) begin
                    state_d = StStop;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (baud_q == StopLast) begin
                    if (!empty_q) begin
                        launch = 1'b1;
                    end else begin
                        state_d = StIdle;
                        baud_d  = '0;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
        // Shared by idle start-up and back-to-back chaining out of the stop bits.
        if (launch) begin
            state_d = StStart;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = head;
            par_d   = (PARITY == 1) ? ~(^head) : (^head);
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (push && !i_reset) begin
            mem[wr_ptr_q] <= i_tx_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            start_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            start_q <= i_tx_start;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CntFull);
            empty_q <= (count_d == '0);
            if (write_req && full_q) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign o_tx         = tx_q;
    assign o_tx_busy    = (state_q != StIdle);
    assign o_tx_done    = (state_q == StStop) && (baud_q == StopLast);
    assign o_fifo_full  = full_q;
    assign o_fifo_empty = empty_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: two instances (8E1 with CLKS_PER_BIT=4, and
// 5O2 with CLKS_PER_BIT=3). Accepted writes are pushed to per-instance
// scoreboard queues; monitor processes decode every frame on the line and
// compare it cycle by cycle against the expected bit sequence.
module tb_uart_tx_fifo;

    localparam int CPB_A = 4, DB_A = 8, PM_A = 2, SB_A = 1, DEPTH_A = 4;
    localparam int CPB_B = 3, DB_B = 5, PM_B = 1, SB_B = 2, DEPTH_B = 2;
    localparam int LEN_A = (1 + DB_A + 1 + SB_A) * CPB_A;

    logic       clk;
    logic       rst_a, start_a, tx_a, busy_a, done_a, full_a, empty_a, ovf_a;
    logic [7:0] data_a;
    logic       rst_b, start_b, tx_b, busy_b, done_b, full_b, empty_b, ovf_b;
    logic [4:0] data_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    bit b_fin = 1'b0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    // Reference model for instance A: occupancy and remaining frame cycles.
    int m_cnt = 0;
    int m_rem = 0;
    bit m_ovf = 1'b0;
    bit m_prev = 1'b0;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB_A), .DATA_BITS(DB_A), .PARITY(PM_A),
        .STOP_BITS(SB_A), .FIFO_DEPTH(DEPTH_A)
    ) u_dut_a (
        .i_clock(clk), .i_reset(rst_a), .i_tx_start(start_a), .i_tx_data(data_a),
        .o_tx(tx_a), .o_tx_busy(busy_a), .o_tx_done(done_a),
        .o_fifo_full(full_a), .o_fifo_empty(empty_a), .o_overflow(ovf_a)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB_B), .DATA_BITS(DB_B), .PARITY(PM_B),
        .STOP_BITS(SB_B), .FIFO_DEPTH(DEPTH_B)
    ) u_dut_b (
        .i_clock(clk), .i_reset(rst_b), .i_tx_start(start_b), .i_tx_data(data_b),
        .o_tx(tx_b), .o_tx_busy(busy_b), .o_tx_done(done_b),
        .o_fifo_full(full_b), .o_fifo_empty(empty_b), .o_overflow(ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Line level of bit slot idx in a frame carrying d (d already masked).
    function automatic logic exp_bit(input logic [7:0] d, input int db, input int pm,
                                     input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= db) return d[idx-1];
        if (pm != 0 && idx == db + 1) return (pm == 1) ? ~(^d) : (^d);
        return 1'b1;
    endfunction

    function automatic logic [2:0] lines(input int inst);
        return (inst == 0) ? {tx_a, busy_a, done_a} : {tx_b, busy_b, done_b};
    endfunction

    function automatic logic rst_of(input int inst);
        return (inst == 0) ? rst_a : rst_b;
    endfunction

    task automatic monitor_loop(input int inst);
        int cpb, db, pm, sb, nb, qsz;
        logic [7:0] d;
        logic [2:0] s;
        logic e, last, exp_busy;
        bit ab;
        cpb = (inst == 0) ? CPB_A : CPB_B;
        db  = (inst == 0) ? DB_A : DB_B;
        pm  = (inst == 0) ? PM_A : PM_B;
        sb  = (inst == 0) ? SB_A : SB_B;
        nb  = 1 + db + ((pm != 0) ? 1 : 0) + sb;
        forever begin
            @(negedge clk);
            s = lines(inst);
            if (mon_en && !rst_of(inst)) begin
                if (s[2] == 1'b0) begin
                    qsz = (inst == 0) ? exp_a.size() : exp_b.size();
                    if (qsz == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL i%0d unexpected_frame: got start bit, want idle line", inst);
                    end else begin
                        if (inst == 0) d = exp_a.pop_front();
                        else d = exp_b.pop_front();
                        ab = 1'b0;
                        for (int b = 0; b < nb && !ab; b++) begin
                            e = exp_bit(d, db, pm, b);
                            for (int c = 0; c < cpb; c++) begin
                                if (b != 0 || c != 0) begin
                                    @(negedge clk);
                                    s = lines(inst);
                                end
                                if (rst_of(inst)) begin
                                    ab = 1'b1;
                                    break;
                                end
                                last = (b == nb - 1) && (c == cpb - 1);
                                check($sformatf("i%0d frame_%02h bit%0d cyc%0d {tx,busy,done}",
                                                inst, d, b, c), 32'(s), 32'({e, 1'b1, last}));
                            end
                        end
                    end
                end else begin
                    exp_busy = (inst == 0) ? (m_rem != 0) : 1'b0;
                    check($sformatf("i%0d idle {busy,done}", inst), 32'(s[1:0]),
                          32'({exp_busy, 1'b0}));
                end
            end
        end
    endtask

    initial monitor_loop(0);
    initial monitor_loop(1);

    always @(negedge clk) begin
        if (mon_en) begin
            check("a_fifo_full", 32'(full_a), 32'(m_cnt == DEPTH_A));
            check("a_fifo_empty", 32'(empty_a), 32'(m_cnt == 0));
            check("a_overflow", 32'(ovf_a), 32'(m_ovf));
        end
    end

    // Spec-level behaviour per edge: the transmitter takes the head when it is
    // idle or finishing a frame; writes are judged against pre-edge occupancy.
    task automatic model_step(input logic s, input logic [7:0] d);
        bit wr, push, pop;
        if (rst_a) begin
            m_cnt = 0;
            m_rem = 0;
            m_ovf = 1'b0;
            m_prev = 1'b0;
            exp_a.delete();
        end else begin
            wr = s && !m_prev;
            m_prev = s;
            pop = (m_rem <= 1) && (m_cnt > 0);
            push = wr && (m_cnt < DEPTH_A);
            if (wr && !push) m_ovf = 1'b1;
            if (push) exp_a.push_back(d);
            if (pop) m_rem = LEN_A;
            else if (m_rem > 0) m_rem--;
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
    endtask

    task automatic tick(input logic s, input logic [7:0] d);
        start_a = s;
        data_a = d;
        @(posedge clk);
        model_step(s, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, data_a);
    endtask

    task automatic send(input logic [7:0] d);
        tick(1'b1, d);
        tick(1'b0, d);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && (m_cnt != 0 || m_rem != 0); i++) tick(1'b0, data_a);
        idle(2);
        check({name, "_empty"}, 32'(empty_a), 32'd1);
        check({name, "_busy"}, 32'(busy_a), 32'd0);
        check({name, "_frames_left"}, 32'(exp_a.size()), 32'd0);
    endtask

    // Instance B: directed and random 5-bit writes, spaced so none is dropped.
    initial begin
        logic [4:0] v;
        rst_b = 1'b1;
        start_b = 1'b0;
        data_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = (i == 0) ? 5'h1F : (i == 1) ? 5'h00 : (i == 2) ? 5'h15 : 5'($urandom);
            start_b = 1'b1;
            data_b = v;
            exp_b.push_back({3'b000, v});
            @(posedge clk);
            #1 start_b = 1'b0;
            repeat (32) @(posedge clk);
            #1;
        end
        // Two writes close together go out back-to-back.
        for (int i = 0; i < 2; i++) begin
            v = 5'($urandom);
            start_b = 1'b1;
            data_b = v;
            exp_b.push_back({3'b000, v});
            @(posedge clk);
            #1 start_b = 1'b0;
            @(posedge clk);
            #1;
        end
        repeat (70) @(posedge clk);
        #1;
        check("b_empty_end", 32'(empty_b), 32'd1);
        check("b_full_end", 32'(full_b), 32'd0);
        check("b_overflow_end", 32'(ovf_b), 32'd0);
        check("b_frames_left", 32'(exp_b.size()), 32'd0);
        b_fin = 1'b1;
    end

    initial begin
        rst_a = 1'b1;
        start_a = 1'b0;
        data_a = '0;
        idle(3);
        rst_a = 1'b0;
        mon_en = 1'b1;
        check("rst_tx", 32'(tx_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_empty", 32'(empty_a), 32'd1);
        check("rst_full", 32'(full_a), 32'd0);
        check("rst_overflow", 32'(ovf_a), 32'd0);

        // Single frames: 0xA5 (even parity bit 0) and 0x01 (even parity bit 1).
        send(8'hA5);
        idle(50);
        send(8'h01);
        idle(50);

        // Level held for 125 cycles: exactly one write.
        for (int i = 0; i < 125; i++) tick(1'b1, 8'($urandom));
        tick(1'b0, 8'h00);
        drain("hold");
        check("hold_overflow", 32'(ovf_a), 32'd0);

        // One write starts a frame, five more during it: four fill, the fifth drops.
        for (int i = 0; i < 6; i++) send(8'($urandom));
        check("burst_full", 32'(full_a), 32'd1);
        check("burst_overflow", 32'(ovf_a), 32'd1);
        drain("burst");

        // Reset twenty cycles into a frame with more bytes queued.
        rst_a = 1'b1;
        idle(1);
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) send(8'($urandom));
        idle(15);
        rst_a = 1'b1;
        idle(1);
        rst_a = 1'b0;
        check("midrst_tx", 32'(tx_a), 32'd1);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_done", 32'(done_a), 32'd0);
        check("midrst_empty", 32'(empty_a), 32'd1);
        idle(60);

        // Start held high across reset release: one write right after reset.
        start_a = 1'b1;
        rst_a = 1'b1;
        tick(1'b1, 8'h3C);
        tick(1'b1, 8'h3C);
        rst_a = 1'b0;
        for (int i = 0; i < 10; i++) tick(1'b1, 8'h3C);
        tick(1'b0, 8'h00);
        drain("across_rst");

        // Random traffic at several write rates, reset between rounds.
        for (int r = 0; r < 3; r++) begin
            int rate;
            rate = (r == 0) ? 2 : (r == 1) ? 15 : 60;
            rst_a = 1'b1;
            idle(1);
            rst_a = 1'b0;
            for (int i = 0; i < 700; i++) begin
                tick(($urandom_range(0, rate) == 0), 8'($urandom));
            end
            tick(1'b0, 8'h00);
            drain($sformatf("rand%0d", r));
        end

        for (int i = 0; i < 5000 && !b_fin; i++) idle(1);
        check("b_finished", 32'(b_fin), 32'd1);
        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

endmodule
